vote_session_ctrl: RTL
======================

Name: vote_session_ctrl

Overview:
- Per-ballot sequencer for the voting machine.
- Arms one ballot on an official's enable, qualifies a single held candidate button, and issues exactly one vote.
- Keeps the four candidate tallies and applies a post-vote lockout.
- Drives valid_vote_casted and the candN_vote buses consumed by the LED controller.

Parameters:
- HOLD_CYCLES, 3, consecutive samples a single button must be held to register (legal range >= 2).
- LOCK_CYCLES, 10, cycles in LOCKOUT after a cast; equals the LED flash length.
- CNT_W, 8, tally width.
- TIMEOUT_CYCLES, 1000, ARMED idle limit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mode  in  1  0 = voting, 1 = result
- ballot_en  in  1  official arms one ballot; level, sampled in IDLE only
- cand1_button_press  in  1  candidate 1 button, debounced
- cand2_button_press  in  1  candidate 2 button, debounced
- cand3_button_press  in  1  candidate 3 button, debounced
- cand4_button_press  in  1  candidate 4 button, debounced
- valid_vote_casted  out  1  one-cycle pulse per accepted vote
- ready  out  1  high while ARMED or HOLD
- multi_press_err  out  1  one-cycle pulse on a rejected multi-button press
- cand1_vote  out  CNT_W  tally for candidate 1
- cand2_vote  out  CNT_W  tally for candidate 2
- cand3_vote  out  CNT_W  tally for candidate 3
- cand4_vote  out  CNT_W  tally for candidate 4

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high.
- Reset values: state=IDLE; all tallies 0; valid_vote_casted, ready, multi_press_err all 0; hold and lock counters 0.
- Reset asserted mid-ballot, including during CAST, abandons the ballot. No tally increments.
- All outputs are registered.
- State IDLE: goes to ARMED when mode=0 and ballot_en=1.
- State ARMED (ready=1):
  - Exactly one button high: go to HOLD, latch the candidate index, hold_cnt=1.
  - Two or more buttons high: pulse multi_press_err for one cycle and stay ARMED.
- State HOLD (ready=1):
  - Latched button still high and every other button low: hold_cnt++.
  - When hold_cnt reaches HOLD_CYCLES, go to CAST.
  - Latched button released, or any other button asserted: return to ARMED. No error is raised.
- State CAST, one cycle:
  - valid_vote_casted=1.
  - The latched tally increments at the edge leaving CAST. It saturates at 2^CNT_W-1 and never wraps.
  - Next state is LOCKOUT.
- State LOCKOUT: runs LOCK_CYCLES cycles with buttons ignored, then goes to RELEASE.
- State RELEASE: waits until all four buttons are low, then goes to IDLE. A new ballot_en is required for the next vote.
- Latency: a button first sampled at edge k and held gives CAST after edge k+HOLD_CYCLES-1. The tally is updated after edge k+HOLD_CYCLES.
- mode=1:
  - In ARMED or HOLD: go to IDLE next edge, ballot discarded.
  - In CAST, LOCKOUT or RELEASE: the sequence completes normally.
  - IDLE does not arm while mode=1.
  - Tallies are preserved across mode changes. Only reset clears them.
- ballot_en held high: arms at most one ballot per pass through IDLE. Holding it high re-arms only after RELEASE completes.

Optional Feature:
- Macro: VOTE_TIMEOUT_EN.
- With the macro defined:
  - An idle counter runs in ARMED. It clears on any button activity.
  - After TIMEOUT_CYCLES with no button activity, the FSM returns to IDLE and the ballot is forfeited.
  - A one-cycle output port timeout_pulse is added.
- Without the macro: ARMED waits indefinitely. There is no timeout_pulse port and no counter logic.

Decomposition:
- Package vote_pkg holds:
  - the state enum (IDLE, ARMED, HOLD, CAST, LOCKOUT, RELEASE);
  - NUM_CAND=4;
  - default HOLD_CYCLES, LOCK_CYCLES and CNT_W;
  - the one-hot-to-index function.
- One sub-module, sat_counter: a CNT_W saturating increment-enable counter, instantiated four times for the tallies.

Test Plan:
- reset, mode=0, ballot_en pulse, cand2 held 3 cycles -> one valid_vote_casted pulse; cand2_vote=1; other tallies 0; ready=0 for the following 10 cycles.
- ARMED, cand1 and cand3 asserted together -> multi_press_err pulses once; no tally change; ready stays 1; a later cand3-only hold gives cand3_vote=1.
- ARMED, cand4 held 2 cycles then released -> back to ARMED; cand4_vote stays 0; a second full 3-cycle hold gives cand4_vote=1.
- Preload cand1_vote to 255 via 255 ballots, then one more cand1 ballot -> valid_vote_casted pulses; cand1_vote stays 255.
- mode=1 asserted while in HOLD -> IDLE next cycle; no pulse; tallies unchanged. Then with mode=0 and a button held through lockout, IDLE is not re-entered until the button is released.
- VOTE_TIMEOUT_EN with TIMEOUT_CYCLES=20: arm and stay idle 20 cycles -> timeout_pulse fires, state returns to IDLE; reset asserted mid-CAST leaves every tally at 0.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and defaults for the ballot sequencer: FSM state encoding,
// candidate count, default timing parameters and the button-to-index helper.
package vote_pkg;

  localparam int NUM_CAND        = 4;
  localparam int IDX_W           = $clog2(NUM_CAND);
  localparam int DEF_HOLD_CYCLES = 3;
  localparam int DEF_LOCK_CYCLES = 10;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    HOLD    = 3'd2,
    CAST    = 3'd3,
    LOCKOUT = 3'd4,
    RELEASE = 3'd5
  } vote_state_t;

  // Callers only pass a vector already known to have exactly one bit set.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_CAND-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Ballot panel bus: official controls and candidate buttons in, vote status and tallies out.
// With VOTE_TIMEOUT_EN defined the bus also carries timeout_pulse.
interface vote_session_ctrl_if
  import vote_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             mode;
  logic             ballot_en;
  logic             cand1_button_press;
  logic             cand2_button_press;
  logic             cand3_button_press;
  logic             cand4_button_press;
  logic             valid_vote_casted;
  logic             ready;
  logic             multi_press_err;
  logic [CNT_W-1:0] cand1_vote;
  logic [CNT_W-1:0] cand2_vote;
  logic [CNT_W-1:0] cand3_vote;
  logic [CNT_W-1:0] cand4_vote;
`ifdef VOTE_TIMEOUT_EN
  logic             timeout_pulse;
`endif

  modport master (
    output mode, ballot_en,
    output cand1_button_press, cand2_button_press, cand3_button_press, cand4_button_press,
    input  valid_vote_casted, ready, multi_press_err,
    input  cand1_vote, cand2_vote, cand3_vote, cand4_vote
`ifdef VOTE_TIMEOUT_EN
    , input timeout_pulse
`endif
  );

  modport slave (
    input  mode, ballot_en,
    input  cand1_button_press, cand2_button_press, cand3_button_press, cand4_button_press,
    output valid_vote_casted, ready, multi_press_err,
    output cand1_vote, cand2_vote, cand3_vote, cand4_vote
`ifdef VOTE_TIMEOUT_EN
    , output timeout_pulse
`endif
  );

endinterface

// File: rtl/sat_counter.sv
// Increment-enable tally counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count
);

  // Reset wins over a coincident increment, so a ballot cut off by reset is never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc_en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// Per-ballot sequencer: arms on ballot_en, qualifies one held button, casts one vote, then locks out.
// Defining VOTE_TIMEOUT_EN adds an ARMED idle timeout and the timeout_pulse output.
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
`ifdef VOTE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input logic                clk,
  input logic                reset,
  vote_session_ctrl_if.slave bus
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
`ifdef VOTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`endif

  vote_state_t         state;
  logic [IDX_W-1:0]    cand_idx;
  logic [HW-1:0]       hold_cnt;
  logic [LW-1:0]       lock_cnt;
  logic                valid_q;
  logic                ready_q;
  logic                err_q;
  logic [NUM_CAND-1:0] btn;
  logic [NUM_CAND-1:0] lat_mask;
  logic                single_press;
  logic                multi_press;
  logic [CNT_W-1:0]    tally [NUM_CAND];
`ifdef VOTE_TIMEOUT_EN
  logic [TW-1:0]       idle_cnt;
  logic                timeout_q;
`endif

  assign btn = {bus.cand4_button_press, bus.cand3_button_press,
                bus.cand2_button_press, bus.cand1_button_press};
  assign lat_mask     = {{(NUM_CAND-1){1'b0}}, 1'b1} << cand_idx;
  assign single_press = $onehot(btn);
  assign multi_press  = (btn != '0) && !single_press;

  // Sequencer; ready is registered alongside each transition so it tracks ARMED/HOLD exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cand_idx <= '0;
      hold_cnt <= '0;
      lock_cnt <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!bus.mode && bus.ballot_en) begin
            state   <= ARMED;
            ready_q <= 1'b1;
`ifdef VOTE_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        ARMED: begin
          if (bus.mode) begin
            state   <= IDLE;
            ready_q <= 1'b0;
          end else if (single_press) begin
            state    <= HOLD;
            cand_idx <= onehot_to_idx(btn);
            hold_cnt <= HW'(1);
          end else if (multi_press) begin
            err_q <= 1'b1;
`ifdef VOTE_TIMEOUT_EN
            idle_cnt <= '0;
          end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            timeout_q <= 1'b1;
            idle_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
`endif
          end
        end
        HOLD: begin
          if (bus.mode) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            hold_cnt <= '0;
          end else if (btn == lat_mask) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
              state   <= CAST;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end
          end else begin
            state    <= ARMED;
            hold_cnt <= '0;
`ifdef VOTE_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        CAST: begin
          state    <= LOCKOUT;
          hold_cnt <= '0;
          lock_cnt <= '0;
        end
        LOCKOUT: begin
          if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
            state    <= RELEASE;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (btn == '0) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // The tally steps on the edge that leaves CAST.
  for (genvar i = 0; i < NUM_CAND; i++) begin : g_tally
    sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_en((state == CAST) && (cand_idx == IDX_W'(i))),
      .count (tally[i])
    );
  end

  assign bus.valid_vote_casted = valid_q;
  assign bus.ready             = ready_q;
  assign bus.multi_press_err   = err_q;
  assign bus.cand1_vote        = tally[0];
  assign bus.cand2_vote        = tally[1];
  assign bus.cand3_vote        = tally[2];
  assign bus.cand4_vote        = tally[3];
`ifdef VOTE_TIMEOUT_EN
  assign bus.timeout_pulse     = timeout_q;
`endif

endmodule
